ddr_mem_model: RTL



---
 rtl/ddr_mem_model_if.sv | 22 ++
 rtl/ddr_mem_model.sv | 99 +++++++++
 2 files changed

// File: rtl/ddr_mem_model_if.sv
// DDR_ift: memory-port bundle between the cache/refill master and the DDR slave.
interface DDR_ift;
    logic [63:0]  raddr_mem;
    logic         ren_mem;
    logic [127:0] rdata_mem;
    logic         rvalid_mem;
    logic [63:0]  waddr_mem;
    logic [127:0] wdata_mem;
    logic [15:0]  wmask_mem;
    logic         wen_mem;
    logic         wvalid_mem;

    modport Slave (
        input  raddr_mem, ren_mem, waddr_mem, wdata_mem, wmask_mem, wen_mem,
        output rdata_mem, rvalid_mem, wvalid_mem
    );

    modport Master (
        output raddr_mem, ren_mem, waddr_mem, wdata_mem, wmask_mem, wen_mem,
        input  rdata_mem, rvalid_mem, wvalid_mem
    );
endinterface

// File: rtl/ddr_mem_model.sv
// ddr_mem_model: fixed-latency 128-bit line backing store on the DDR slave port.
// Define DDR_MEM_RAND_LAT_EN to add an LFSR-driven 0..3 cycle extra latency per request.
module ddr_mem_model #(
    parameter int          MEM_DEPTH = 4096,
    parameter int          LATENCY   = 4,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input logic   clk,
    input logic   rst,
    DDR_ift.Slave mem_ift
);
    localparam int         IW     = $clog2(MEM_DEPTH);
    localparam logic [8:0] LAT_M1 = 9'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WWAIT, RWAIT, GAP} state_t;

    state_t        state, state_nxt;
    logic [8:0]    cnt, cnt_nxt, load, extra;
    logic          accept_w, accept_r, done, wvalid, rvalid;
    logic [IW-1:0] wline;
    logic [127:0]  wdata, rline;
    logic [15:0]   wmask;
    logic [127:0]  mem [MEM_DEPTH];

    function automatic logic [IW-1:0] line_of(input logic [63:0] a);
        return IW'((a - BASE_ADDR) >> 4);
    endfunction

`ifdef DDR_MEM_RAND_LAT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (accept_w || accept_r)
            lfsr <= {~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]), lfsr[7:1]};
    end

    assign extra = {7'd0, lfsr[1:0]};
`else
    assign extra = 9'd0;
`endif

    always_comb begin
        accept_w  = (state == IDLE) && mem_ift.wen_mem;
        accept_r  = (state == IDLE) && !mem_ift.wen_mem && mem_ift.ren_mem;
        done      = (cnt == 9'd0);
        load      = LAT_M1 + extra;
        wvalid    = (state == WWAIT) && done;
        rvalid    = (state == RWAIT) && done;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_w || accept_r) begin
                    state_nxt = accept_w ? WWAIT : RWAIT;
                    cnt_nxt   = load;
                end
            end
            WWAIT, RWAIT: begin
                state_nxt = done ? GAP : state;
                cnt_nxt   = done ? cnt : cnt - 9'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 9'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_w) begin
            wline <= line_of(mem_ift.waddr_mem);
            wdata <= mem_ift.wdata_mem;
            wmask <= mem_ift.wmask_mem;
        end
    end

    // Only one transaction is ever in flight, so the line can be fetched at acceptance.
    always_ff @(posedge clk) begin
        if (accept_r)
            rline <= mem[line_of(mem_ift.raddr_mem)];
        if (wvalid && !rst)
            for (int i = 0; i < 16; i++)
                if (wmask[i])
                    mem[wline][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign mem_ift.wvalid_mem = wvalid;
    assign mem_ift.rvalid_mem = rvalid;
    assign mem_ift.rdata_mem  = rvalid ? rline : 128'd0;
endmodule
